// File: rtl/psr_flag_ctrl.sv
// Processor status register flag control: six architectural flags, the SO pin
// edge detector and the instruction-boundary interrupt mask.
module psr_flag_ctrl (
  input  logic       phi2,
  input  logic       resb,
  input  logic [3:0] flag_op,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [7:0] db_in,
  input  logic       so_n,
  input  logic       sync,
  input  logic       push_brk,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  output logic       irq_mask,
  output logic       so_event
);

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_LD_NZ     = 4'd1,
    OP_LD_NZC    = 4'd2,
    OP_LD_NZCV   = 4'd3,
    OP_LD_BIT    = 4'd4,
    OP_LD_Z      = 4'd5,
    OP_CLC       = 4'd6,
    OP_SEC       = 4'd7,
    OP_CLI       = 4'd8,
    OP_SEI       = 4'd9,
    OP_CLD       = 4'd10,
    OP_SED       = 4'd11,
    OP_CLV       = 4'd12,
    OP_PULL      = 4'd13,
    OP_INT_ENTRY = 4'd14,
    OP_RSVD      = 4'd15
  } flag_op_e;

  flag_op_e op;
  assign op = flag_op_e'(flag_op);

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic so_sync1_q, so_sync2_q, so_prev_q;
  logic irq_mask_q, irq_mask_d;
  logic so_event_q;
  logic so_fall;

  // The unused B/bit-5 positions of a pulled byte are deliberately dropped.
  logic unused_db;
  assign unused_db = ^db_in[5:4];

  assign so_fall = so_prev_q & ~so_sync2_q;

  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    case (op)
      OP_LD_NZ: begin
        n_d = alu_n;
        z_d = alu_z;
      end
      OP_LD_NZC: begin
        n_d = alu_n;
        z_d = alu_z;
        c_d = alu_c;
      end
      OP_LD_NZCV: begin
        n_d = alu_n;
        z_d = alu_z;
        c_d = alu_c;
        v_d = alu_v;
      end
      OP_LD_BIT: begin
        n_d = db_in[7];
        v_d = db_in[6];
        z_d = alu_z;
      end
      OP_LD_Z:   z_d = alu_z;
      OP_CLC:    c_d = 1'b0;
      OP_SEC:    c_d = 1'b1;
      OP_CLI:    i_d = 1'b0;
      OP_SEI:    i_d = 1'b1;
      OP_CLD:    d_d = 1'b0;
      OP_SED:    d_d = 1'b1;
      OP_CLV:    v_d = 1'b0;
      OP_PULL: begin
        n_d = db_in[7];
        v_d = db_in[6];
        d_d = db_in[3];
        i_d = db_in[2];
        z_d = db_in[1];
        c_d = db_in[0];
      end
      OP_INT_ENTRY: begin
        i_d = 1'b1;
        d_d = 1'b0;
      end
      default: ;
    endcase
    // The SO pin has priority over any opcode that writes V on the same edge.
    if (so_fall) begin
      v_d = 1'b1;
    end
  end

  // The mask samples the pre-update I so flag changes act one instruction late.
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (op == OP_INT_ENTRY) begin
      irq_mask_d = 1'b1;
    end else if (sync) begin
      irq_mask_d = i_q;
    end
  end

  always_ff @(posedge phi2 or negedge resb) begin
    if (!resb) begin
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      d_q        <= 1'b0;
      i_q        <= 1'b1;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      so_sync1_q <= 1'b1;
      so_sync2_q <= 1'b1;
      so_prev_q  <= 1'b1;
      irq_mask_q <= 1'b1;
      so_event_q <= 1'b0;
    end else begin
      n_q        <= n_d;
      v_q        <= v_d;
      d_q        <= d_d;
      i_q        <= i_d;
      z_q        <= z_d;
      c_q        <= c_d;
      so_sync1_q <= so_n;
      so_sync2_q <= so_sync1_q;
      so_prev_q  <= so_sync2_q;
      irq_mask_q <= irq_mask_d;
      so_event_q <= so_fall;
    end
  end

  assign p_out    = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign p_push   = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  assign irq_mask = irq_mask_q;
  assign so_event = so_event_q;

endmodule

// File: doc/psr_flag_ctrl.md
PSR_FLAG_CTRL -- requirements
Module: psr_flag_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: phi2 is the clock (rising edge), resb is the asynchronous active-low reset.
REQ-002 Port list SHALL be:
- phi2  in  1  clock
- resb  in  1  async reset, active low
- flag_op  in  4  flag command, sampled every edge
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU result flags
- db_in  in  8  data bus (PLP/RTI pull, BIT operand)
- so_n  in  1  set-overflow pin, asynchronous
- sync  in  1  opcode-fetch cycle marker
- push_brk  in  1  B value for pushed image (1 = BRK/PHP, 0 = IRQ/NMI)
- p_out  out  8  architectural status {N,V,1,1,D,I,Z,C}, to status register / decode
- p_push  out  8  stack image {N,V,1,push_brk,D,I,Z,C}
- irq_mask  out  1  effective interrupt mask seen by interrupt logic
- so_event  out  1  one-cycle pulse when an SO falling edge is applied

Function
REQ-003 Internal state SHALL be six flag flops N,V,D,I,Z,C, a 2-flop so_n synchronizer plus a previous-value flop, and an irq_mask flop.
REQ-004 p_out bits 5 and 4 SHALL always read 1; p_push bit 5 SHALL read 1 and bit 4 SHALL equal push_brk (combinational from current flags).
REQ-005 flag_op SHALL be decoded per edge, one-cycle effect, flags not named SHALL hold:
- 0 NOP
- 1 LD_NZ: N<=alu_n, Z<=alu_z
- 2 LD_NZC: adds C<=alu_c
- 3 LD_NZCV: adds V<=alu_v
- 4 LD_BIT: N<=db_in[7], V<=db_in[6], Z<=alu_z
- 5 LD_Z: Z<=alu_z
- 6 CLC, 7 SEC, 8 CLI, 9 SEI, 10 CLD, 11 SED, 12 CLV
- 13 PULL: N,V,D,I,Z,C <= db_in[7,6,3,2,1,0]; db_in[5:4] ignored
- 14 INT_ENTRY: I<=1, D<=0
- 15 reserved, behaves as NOP
REQ-006 so_n SHALL pass through two phi2 flops; a falling edge is sync2 low while the previous sample was high.
REQ-007 A detected SO falling edge SHALL set V<=1 on that same edge and pulse so_event high for exactly one cycle; a low level held on so_n SHALL NOT retrigger.
REQ-008 If an SO edge coincides with a flag_op writing V (3, 4, 12, 13), V SHALL end at 1 (SO wins); all other fields of that op SHALL still apply.
REQ-009 Latency: p_out SHALL reflect a flag_op on the cycle after the edge that samples it; so_n to V SHALL be 3 edges worst case.
REQ-010 irq_mask SHALL load the registered I value (pre-update) on each edge where sync=1, so CLI/SEI/PLP take effect at the next instruction boundary, one instruction late.
REQ-011 INT_ENTRY SHALL additionally force irq_mask<=1 on the same edge, overriding a simultaneous sync load.
REQ-012 With sync=0 and flag_op not INT_ENTRY, irq_mask SHALL hold regardless of I changes.
REQ-013 Flag updates and irq_mask loads on the same edge SHALL both occur; irq_mask SHALL use the old I.

Reset
REQ-014 resb low SHALL asynchronously set N=V=Z=C=0, D=0, I=1, irq_mask=1, sync flops and previous-value flop=1, and so_event=0; p_out SHALL read 0x34.
REQ-015 Deassertion SHALL be synchronous to phi2; the first active edge SHALL treat so_n as previously high, so so_n held low through reset SHALL produce one SO event after release.
REQ-016 Reset asserted mid-operation SHALL override any flag_op or SO edge in progress.

Verification
REQ-017 Reset, then idle -> p_out=0x34, irq_mask=1, p_push with push_brk=0 = 0x24.
REQ-018 flag_op=13, db_in=0xFF, then flag_op=0 -> p_out=0xFF; with push_brk=0 -> p_push=0xEF.
REQ-019 From reset, CLI with sync=0, then sync=1 for one edge -> irq_mask stays 1 through the CLI edge and goes 0 after the sync edge.
REQ-020 so_n 1->0 held low 10 cycles -> V=1 three edges later, single so_event pulse; CLV afterwards -> V=0 with no new event.
REQ-021 flag_op=12 (CLV) on the same edge as a detected SO edge -> V=1.
REQ-022 flag_op=14 with sync=1 and I=0 -> I=1, D=0, irq_mask=1 next cycle; then flag_op=3 with alu_n,z,c,v=1,0,1,1 -> p_out=0xF5.
